// File: rtl/macc_ctrl.sv
// MAC unit controller for one processing element: sequences 1-D convolution
// (optionally with the clip/shift outer loop), the psum accumulate pass, and
// holds the 36-bit accumulator register.
module macc_ctrl #(
  parameter int DATA_WIDTH      = 16,
  parameter int IFPAD_WIDTH     = 4,
  parameter int WPAD_WIDTH      = 8,
  parameter int OFPAD_WIDTH     = 4,
  parameter int OUT_DATA_WIDTH  = 36,
  parameter int MAX_CLIP_WIDTH  = 5,
  parameter int MAX_SHIFT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IFPAD_WIDTH-1:0]     Para_1Dconv_len,
  input  logic [OFPAD_WIDTH-1:0]     Para_filter_num,
  input  logic [MAX_CLIP_WIDTH-1:0]  Para_clip_num_max,
  input  logic [MAX_SHIFT_WIDTH-1:0] Para_shift_num_max,
  input  logic                       mode,
  input  logic                       mac_begin,
  input  logic                       acc_begin,
  input  logic                       interrupt,
  input  logic                       restore,
  input  logic [DATA_WIDTH-1:0]      external_psum,
  input  logic [DATA_WIDTH-1:0]      internal_psum,
  input  logic [DATA_WIDTH-1:0]      ifmap_in,
  input  logic [DATA_WIDTH-1:0]      weight_in,
  output logic                       first_clip_flag,
  output logic                       mac_finish_flag,
  output logic                       acc_finish_flag,
  output logic                       mul_enable_flag,
  output logic                       psum_initial_flag,
  output logic                       acc_enable_flag,
  output logic                       psum_store_flag,
  output logic [1:0]                 accumulate_mode,
  output logic [IFPAD_WIDTH-1:0]     cnt_a,
  output logic [OFPAD_WIDTH-1:0]     cnt_b,
  output logic [MAX_SHIFT_WIDTH-1:0] cnt_shift,
  output logic [MAX_CLIP_WIDTH-1:0]  cnt_clip,
  output logic [OUT_DATA_WIDTH-1:0]  accum_out
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int PX_W   = OUT_DATA_WIDTH - PROD_W;
  localparam int DX_W   = OUT_DATA_WIDTH - DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, MAC, PAUSE, ACC, DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [IFPAD_WIDTH-1:0]     len_q, len_d, cnt_a_q, cnt_a_d;
  logic [OFPAD_WIDTH-1:0]     fnum_q, fnum_d, cnt_b_q, cnt_b_d;
  logic [MAX_SHIFT_WIDTH-1:0] smax_q, smax_d, cnt_shift_q, cnt_shift_d;
  logic [MAX_CLIP_WIDTH-1:0]  cmax_q, cmax_d, cnt_clip_q, cnt_clip_d;
  logic                       mode_q, mode_d;
  logic [1:0]                 acc_mode_q, acc_mode_d;
  logic                       mul_en_q, mul_en_d;
  logic                       acc_en_q, acc_en_d;
  logic                       psum_init_q, psum_init_d;
  logic                       first_clip_q, first_clip_d;
  logic                       store_q, store_d;
  logic                       mac_fin_q, mac_fin_d;
  logic                       acc_fin_q, acc_fin_d;
  logic [OUT_DATA_WIDTH-1:0]  accum_q, accum_d;
  // e1 stage: attributes of the issue made one cycle earlier
  logic                       e1_valid_q, e1_valid_d;
  logic                       e1_rowend_q, e1_rowend_d;
  logic                       e1_final_q, e1_final_d;
  logic                       e1_acc_q, e1_acc_d;
  logic                       e1_clip_nz_q, e1_clip_nz_d;

  logic [PROD_W-1:0]          ifm_x, wgt_x, prod;
  logic [OUT_DATA_WIDTH-1:0]  prod_x, ext_x, int_x, base;
  logic                       mac_issue, acc_issue;
  logic                       a_last, b_last, sh_last, cl_last, all_last;

  // Sign-extended operands and the row-start base selection
  always_comb begin
    ifm_x  = {{DATA_WIDTH{ifmap_in[DATA_WIDTH-1]}}, ifmap_in};
    wgt_x  = {{DATA_WIDTH{weight_in[DATA_WIDTH-1]}}, weight_in};
    prod   = ifm_x * wgt_x;
    prod_x = {{PX_W{prod[PROD_W-1]}}, prod};
    ext_x  = {{DX_W{external_psum[DATA_WIDTH-1]}}, external_psum};
    int_x  = {{DX_W{internal_psum[DATA_WIDTH-1]}}, internal_psum};
    base   = accum_q;
    if (psum_init_q) begin
      base = e1_clip_nz_q ? int_x : '0;
    end
  end

  // Next-state, counter sequencing and e1 pipeline
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    fnum_d       = fnum_q;
    smax_d       = smax_q;
    cmax_d       = cmax_q;
    mode_d       = mode_q;
    acc_mode_d   = acc_mode_q;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;
    cnt_shift_d  = cnt_shift_q;
    cnt_clip_d   = cnt_clip_q;
    accum_d      = accum_q;

    // an interrupt cancels the issue shown that cycle; it is reissued on restore
    mac_issue = (state_q == MAC) && !interrupt;
    acc_issue = (state_q == ACC);
    a_last    = (cnt_a_q == len_q - IFPAD_WIDTH'(1));
    b_last    = (cnt_b_q == fnum_q - OFPAD_WIDTH'(1));
    sh_last   = (cnt_shift_q == smax_q);
    cl_last   = (cnt_clip_q == cmax_q);
    all_last  = a_last && b_last && (!mode_q || (sh_last && cl_last));

    e1_valid_d   = mac_issue || acc_issue;
    e1_rowend_d  = acc_issue || (mac_issue && a_last);
    e1_final_d   = (mac_issue && all_last) || (acc_issue && b_last);
    e1_acc_d     = acc_issue;
    e1_clip_nz_d = mode_q && (cnt_clip_q != '0);
    psum_init_d  = mac_issue && (cnt_a_q == '0);

    if (e1_valid_q) begin
      if (e1_acc_q) accum_d = int_x + ext_x;
      else          accum_d = prod_x + base + ext_x;
    end
    store_d   = e1_valid_q && e1_rowend_q;
    mac_fin_d = e1_valid_q && e1_final_q && !e1_acc_q;
    acc_fin_d = e1_valid_q && e1_final_q && e1_acc_q;

    unique case (state_q)
      IDLE: begin
        if (mac_begin) begin
          if ((Para_1Dconv_len != '0) && (Para_filter_num != '0)) begin
            state_d    = MAC;
            len_d      = Para_1Dconv_len;
            fnum_d     = Para_filter_num;
            smax_d     = Para_shift_num_max;
            cmax_d     = Para_clip_num_max;
            mode_d     = mode;
            acc_mode_d = 2'b01;
          end
        end else if (acc_begin && !mode && (Para_filter_num != '0)) begin
          state_d    = ACC;
          fnum_d     = Para_filter_num;
          mode_d     = 1'b0;
          acc_mode_d = 2'b10;
        end
      end
      MAC: begin
        if (interrupt) begin
          state_d = PAUSE;
        end else if (all_last) begin
          state_d     = DRAIN;
          cnt_a_d     = '0;
          cnt_b_d     = '0;
          cnt_shift_d = '0;
          cnt_clip_d  = '0;
        end else if (!a_last) begin
          cnt_a_d = cnt_a_q + IFPAD_WIDTH'(1);
        end else begin
          cnt_a_d = '0;
          if (!b_last) begin
            cnt_b_d = cnt_b_q + OFPAD_WIDTH'(1);
          end else begin
            cnt_b_d = '0;
            if (!sh_last) begin
              cnt_shift_d = cnt_shift_q + MAX_SHIFT_WIDTH'(1);
            end else begin
              cnt_shift_d = '0;
              cnt_clip_d  = cnt_clip_q + MAX_CLIP_WIDTH'(1);
            end
          end
        end
      end
      PAUSE: begin
        if (restore) state_d = MAC;
      end
      ACC: begin
        if (b_last) begin
          state_d = DRAIN;
          cnt_b_d = '0;
        end else begin
          cnt_b_d = cnt_b_q + OFPAD_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (mac_fin_q || acc_fin_q) begin
          state_d    = IDLE;
          acc_mode_d = 2'b00;
          mode_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    mul_en_d     = (state_d == MAC);
    acc_en_d     = (state_d == ACC);
    first_clip_d = mode_d && ((state_d == MAC) || (state_d == PAUSE)) && (cnt_clip_d == '0);
  end

  // State, counters, flags and accumulator registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      fnum_q       <= '0;
      smax_q       <= '0;
      cmax_q       <= '0;
      mode_q       <= 1'b0;
      acc_mode_q   <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      cnt_shift_q  <= '0;
      cnt_clip_q   <= '0;
      mul_en_q     <= 1'b0;
      acc_en_q     <= 1'b0;
      psum_init_q  <= 1'b0;
      first_clip_q <= 1'b0;
      store_q      <= 1'b0;
      mac_fin_q    <= 1'b0;
      acc_fin_q    <= 1'b0;
      accum_q      <= '0;
      e1_valid_q   <= 1'b0;
      e1_rowend_q  <= 1'b0;
      e1_final_q   <= 1'b0;
      e1_acc_q     <= 1'b0;
      e1_clip_nz_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      fnum_q       <= fnum_d;
      smax_q       <= smax_d;
      cmax_q       <= cmax_d;
      mode_q       <= mode_d;
      acc_mode_q   <= acc_mode_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      cnt_shift_q  <= cnt_shift_d;
      cnt_clip_q   <= cnt_clip_d;
      mul_en_q     <= mul_en_d;
      acc_en_q     <= acc_en_d;
      psum_init_q  <= psum_init_d;
      first_clip_q <= first_clip_d;
      store_q      <= store_d;
      mac_fin_q    <= mac_fin_d;
      acc_fin_q    <= acc_fin_d;
      accum_q      <= accum_d;
      e1_valid_q   <= e1_valid_d;
      e1_rowend_q  <= e1_rowend_d;
      e1_final_q   <= e1_final_d;
      e1_acc_q     <= e1_acc_d;
      e1_clip_nz_q <= e1_clip_nz_d;
    end
  end

  assign first_clip_flag   = first_clip_q;
  assign mac_finish_flag   = mac_fin_q;
  assign acc_finish_flag   = acc_fin_q;
  assign mul_enable_flag   = mul_en_q;
  assign psum_initial_flag = psum_init_q;
  assign acc_enable_flag   = acc_en_q;
  assign psum_store_flag   = store_q;
  assign accumulate_mode   = acc_mode_q;
  assign cnt_a             = cnt_a_q;
  assign cnt_b             = cnt_b_q;
  assign cnt_shift         = cnt_shift_q;
  assign cnt_clip          = cnt_clip_q;
  assign accum_out         = accum_q;

endmodule

// File: tb/tb_macc_ctrl.sv
// Self-checking bench for macc_ctrl: table of MAC jobs plus hand-written
// pause, accumulate, ignored-begin and mid-job reset sequences.
module tb_macc_ctrl;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int OW = 4;
  localparam int AW = 36;
  localparam int CW = 5;
  localparam int SW = 4;
  localparam longint unsigned MASK = 64'h0000_000F_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] Para_1Dconv_len;
  logic [OW-1:0] Para_filter_num;
  logic [CW-1:0] Para_clip_num_max;
  logic [SW-1:0] Para_shift_num_max;
  logic          mode, mac_begin, acc_begin, interrupt, restore;
  logic [DW-1:0] external_psum, internal_psum, ifmap_in, weight_in;
  logic          first_clip_flag, mac_finish_flag, acc_finish_flag, mul_enable_flag;
  logic          psum_initial_flag, acc_enable_flag, psum_store_flag;
  logic [1:0]    accumulate_mode;
  logic [IW-1:0] cnt_a;
  logic [OW-1:0] cnt_b;
  logic [SW-1:0] cnt_shift;
  logic [CW-1:0] cnt_clip;
  logic [AW-1:0] accum_out;

  always #5 clk = ~clk;

  macc_ctrl #(
    .DATA_WIDTH(DW), .IFPAD_WIDTH(IW), .WPAD_WIDTH(8), .OFPAD_WIDTH(OW),
    .OUT_DATA_WIDTH(AW), .MAX_CLIP_WIDTH(CW), .MAX_SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .Para_1Dconv_len(Para_1Dconv_len), .Para_filter_num(Para_filter_num),
    .Para_clip_num_max(Para_clip_num_max), .Para_shift_num_max(Para_shift_num_max),
    .mode(mode), .mac_begin(mac_begin), .acc_begin(acc_begin),
    .interrupt(interrupt), .restore(restore),
    .external_psum(external_psum), .internal_psum(internal_psum),
    .ifmap_in(ifmap_in), .weight_in(weight_in),
    .first_clip_flag(first_clip_flag), .mac_finish_flag(mac_finish_flag),
    .acc_finish_flag(acc_finish_flag), .mul_enable_flag(mul_enable_flag),
    .psum_initial_flag(psum_initial_flag), .acc_enable_flag(acc_enable_flag),
    .psum_store_flag(psum_store_flag), .accumulate_mode(accumulate_mode),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_shift(cnt_shift), .cnt_clip(cnt_clip),
    .accum_out(accum_out)
  );

  typedef struct {
    string name;
    bit    md;
    int    L, F, S, C;
    int    ifm, wt, ip, ep;
    longint r0, r1;      // row result for clip-0 rows / later clip rows
    int    rows, clip0_rows, issues;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  longint unsigned exp_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic longint unsigned all_outs();
    return longint'({first_clip_flag, mac_finish_flag, acc_finish_flag, mul_enable_flag,
                     psum_initial_flag, acc_enable_flag, psum_store_flag, accumulate_mode,
                     cnt_a, cnt_b, cnt_shift, cnt_clip, accum_out});
  endfunction

  task automatic set_job(input vec_t v);
    Para_1Dconv_len    = IW'(v.L);
    Para_filter_num    = OW'(v.F);
    Para_shift_num_max = SW'(v.S);
    Para_clip_num_max  = CW'(v.C);
    mode               = v.md;
    ifmap_in           = DW'(v.ifm);
    weight_in          = DW'(v.wt);
    internal_psum      = DW'(v.ip);
    external_psum      = DW'(v.ep);
  endtask

  task automatic run_job(input vec_t v);
    int cyc, fin, en_cnt, fc_cnt, pi_cnt, stores, mode_bad;
    set_job(v);
    for (int r = 0; r < v.rows; r++)
      exp_q.push_back(((r < v.clip0_rows) ? v.r0 : v.r1) & MASK);
    mac_begin = 1'b1;
    tick();
    mac_begin = 1'b0;
    cyc = 1; fin = -1; en_cnt = 0; fc_cnt = 0; pi_cnt = 0; stores = 0; mode_bad = 0;
    while (cyc <= 400) begin
      if (mul_enable_flag) en_cnt++;
      if (mul_enable_flag && first_clip_flag) fc_cnt++;
      if (psum_initial_flag) pi_cnt++;
      if (accumulate_mode != 2'b01) mode_bad++;
      if (psum_store_flag) begin
        stores++;
        if (exp_q.size() == 0) chk({v.name, "_sb_empty"}, 1, 0);
        else chk({v.name, "_psum"}, accum_out, exp_q.pop_front());
      end
      if (mac_finish_flag) begin
        chk({v.name, "_fin_with_store"}, psum_store_flag, 1);
        fin = cyc;
        break;
      end
      tick();
      cyc++;
    end
    chk({v.name, "_finish_cycle"}, fin, v.issues + 2);
    chk({v.name, "_mul_en_cycles"}, en_cnt, v.issues);
    chk({v.name, "_first_clip_cycles"}, fc_cnt, v.md ? v.clip0_rows * v.L : 0);
    chk({v.name, "_psum_init_cycles"}, pi_cnt, v.rows);
    chk({v.name, "_stores"}, stores, v.rows);
    chk({v.name, "_mode01"}, mode_bad, 0);
    exp_q.delete();
    tick();
    chk({v.name, "_mode_after"}, accumulate_mode, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, fin, en_cnt, stores, mode_bad, int_cyc, frozen_bad, prev_b, cnt_ev;
    bit prev_en;
    int ext_tab[3];
    vec_t pv;

    ext_tab = '{1, 2, 3};
    vecs[0] = '{"m0_basic", 1'b0, 12, 3, 0, 0,      2,      3,    9, 0, 72,  72, 3, 3, 36};
    vecs[1] = '{"m1_clip",  1'b1,  2, 1, 1, 1,      1,      1,    5, 0,  2,   7, 4, 2,  8};
    vecs[2] = '{"m0_minmax",1'b0, 15, 1, 0, 0, -32768, -32768,    0, 0, 64'd16106127360, 64'd16106127360, 1, 1, 15};
    vecs[3] = '{"m0_neg",   1'b0,  1, 2, 0, 0,     -3,      5,    0, 4, -11, -11, 2, 2,  2};
    vecs[4] = '{"m1_deep",  1'b1,  3, 2, 0, 2,      7,     -2, -100, 1, -39, -139, 6, 2, 18};

    rst = 1'b0;
    Para_1Dconv_len = '0; Para_filter_num = '0; Para_clip_num_max = '0; Para_shift_num_max = '0;
    mode = 1'b0; mac_begin = 1'b0; acc_begin = 1'b0; interrupt = 1'b0; restore = 1'b0;
    external_psum = '0; internal_psum = '0; ifmap_in = '0; weight_in = '0;
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_job(vecs[i]);

    // pause at cnt_a=5/cnt_b=1, restore six cycles later
    pv = vecs[0];
    set_job(pv);
    for (int r = 0; r < 3; r++) exp_q.push_back(72);
    mac_begin = 1'b1;
    tick();
    mac_begin = 1'b0;
    cyc = 1; fin = -1; en_cnt = 0; stores = 0; int_cyc = -1; frozen_bad = 0;
    while (cyc <= 400) begin
      interrupt = 1'b0;
      restore   = 1'b0;
      if (mul_enable_flag) en_cnt++;
      if (int_cyc < 0 && mul_enable_flag && cnt_a == 5 && cnt_b == 1) begin
        interrupt = 1'b1;
        int_cyc = cyc;
      end else if (int_cyc > 0 && cyc > int_cyc && cyc <= int_cyc + 6) begin
        if (mul_enable_flag || cnt_a != 5 || cnt_b != 1 || accumulate_mode != 2'b01) frozen_bad++;
        if (cyc == int_cyc + 6) restore = 1'b1;
      end
      if (psum_store_flag) begin
        stores++;
        if (exp_q.size() == 0) chk("pause_sb_empty", 1, 0);
        else chk("pause_psum", accum_out, exp_q.pop_front());
      end
      if (mac_finish_flag) begin
        fin = cyc;
        break;
      end
      tick();
      cyc++;
    end
    interrupt = 1'b0;
    restore   = 1'b0;
    chk("pause_int_cycle", int_cyc, 18);
    chk("pause_frozen", frozen_bad, 0);
    chk("pause_finish_cycle", fin, 45);
    chk("pause_mul_en_cycles", en_cnt, 37);
    chk("pause_stores", stores, 3);
    exp_q.delete();
    tick();

    // accumulate pass with per-cycle external psum
    Para_filter_num = 4'd3; mode = 1'b0; internal_psum = 16'd10; external_psum = '0;
    acc_begin = 1'b1;
    tick();
    acc_begin = 1'b0;
    cyc = 1; fin = -1; en_cnt = 0; stores = 0; mode_bad = 0; prev_en = 1'b0; prev_b = 0;
    while (cyc <= 100) begin
      if (acc_enable_flag) en_cnt++;
      if (accumulate_mode != 2'b10 || mul_enable_flag) mode_bad++;
      if (psum_store_flag) begin
        stores++;
        if (exp_q.size() == 0) chk("acc_sb_empty", 1, 0);
        else chk("acc_psum", accum_out, exp_q.pop_front());
      end
      if (acc_finish_flag) begin
        chk("acc_fin_with_store", psum_store_flag, 1);
        fin = cyc;
        break;
      end
      if (prev_en && prev_b < 3) begin
        external_psum = DW'(ext_tab[prev_b]);
        exp_q.push_back(longint'(10 + ext_tab[prev_b]));
      end else begin
        external_psum = '0;
      end
      prev_en = acc_enable_flag;
      prev_b  = int'(cnt_b);
      tick();
      cyc++;
    end
    chk("acc_finish_cycle", fin, 5);
    chk("acc_en_cycles", en_cnt, 3);
    chk("acc_stores", stores, 3);
    chk("acc_mode10", mode_bad, 0);
    exp_q.delete();
    tick();
    chk("acc_mode_after", accumulate_mode, 0);

    // begins that must be ignored
    mode = 1'b1; Para_filter_num = 4'd3;
    acc_begin = 1'b1;
    tick();
    acc_begin = 1'b0;
    chk("acc_begin_mode1_ignored", {accumulate_mode, acc_enable_flag}, 0);
    mode = 1'b0; Para_1Dconv_len = '0;
    mac_begin = 1'b1;
    tick();
    mac_begin = 1'b0;
    chk("mac_begin_l0_ignored", {accumulate_mode, mul_enable_flag}, 0);
    tick();
    chk("mac_begin_l0_idle", {accumulate_mode, mul_enable_flag}, 0);

    // reset in the middle of a mode-1 job
    set_job(vecs[4]);
    mac_begin = 1'b1;
    tick();
    mac_begin = 1'b0;
    repeat (10) tick();
    chk("midjob_active", (accumulate_mode == 2'b01) && (accum_out != '0), 1);
    rst = 1'b0;
    tick();
    chk("midjob_reset_outputs", all_outs(), 0);
    rst = 1'b1;
    cnt_ev = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (mac_finish_flag || psum_store_flag || mul_enable_flag) cnt_ev++;
    end
    chk("midjob_no_finish", cnt_ev, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
